// File: rtl/lpc_reg_responder_if.sv
// lpc_reg_responder_if: decoded LPC cycle inputs, LAD response and board-side register signals
interface lpc_reg_responder_if;
  logic LpcFrame;
  logic Opcode;
  logic Wr;
  logic [7:0] AddrReg;
  logic [7:0] DataWr;
  logic [10:6] DecState;
  logic AccessHit;
  logic [7:0] Data80;
  logic [7:0] StatusIn;
  logic [3:0] LpcDout;
  logic LpcOe;
  logic [47:0] CtrlOut;
  logic RdBusy;
  modport master (
    output LpcFrame, Opcode, Wr, AddrReg, DataWr, DecState, AccessHit, Data80, StatusIn,
    input LpcDout, LpcOe, CtrlOut, RdBusy
  );
  modport slave (
    input LpcFrame, Opcode, Wr, AddrReg, DataWr, DecState, AccessHit, Data80, StatusIn,
    output LpcDout, LpcOe, CtrlOut, RdBusy
  );
endinterface

// File: rtl/lpc_reg_responder.sv
// lpc_reg_responder: board register bank for the 32-port LPC I/O window and its read response FSM
module lpc_reg_responder #(
  parameter logic [7:0] BOARD_ID = 8'hA5,
  parameter logic [7:0] CPLD_REV = 8'h10,
  parameter logic [47:0] CTRL_RST = 48'h0
) (
  input logic LpcClock,
  input logic PciReset,
  lpc_reg_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SYNC, DLO, DHI, TAR} state_t;
  state_t state;
  logic [7:0] latch;
  logic [7:0] status;
  logic [5:0][7:0] ctrl;
  logic [3:0] dout;
  logic oe;
  logic [4:0] offset;
  logic [2:0] ctrlIdx;
  logic ctrlHit;
  logic [7:0] clr;
  logic [7:0] rdVal;
  logic launch;
  assign offset = bus.AddrReg[4:0];
  assign ctrlIdx = offset[2:0] - 3'd2;
  assign ctrlHit = offset >= 5'h02 && offset <= 5'h07;
  assign clr = (bus.Wr && offset == 5'h09) ? bus.DataWr : 8'h00;
  assign launch = bus.DecState[6] && bus.AccessHit && !bus.Opcode && bus.LpcFrame;
  assign rdVal = offset == 5'h00 ? BOARD_ID :
                 offset == 5'h01 ? CPLD_REV :
                 ctrlHit ? ctrl[ctrlIdx] :
                 offset == 5'h08 ? bus.Data80 :
                 offset == 5'h09 ? status : 8'hFF;
  always_ff @(posedge LpcClock or negedge PciReset)
    if (!PciReset) begin
      state <= IDLE;
      latch <= 8'h00;
      oe <= 1'b0;
      dout <= 4'h0;
      ctrl <= CTRL_RST;
      status <= 8'h00;
    end else begin
      status <= (status & ~clr) | bus.StatusIn;
      if (bus.Wr && ctrlHit) ctrl[ctrlIdx] <= bus.DataWr;
      if (state != IDLE && !bus.LpcFrame) begin
        state <= IDLE;
        oe <= 1'b0;
        dout <= 4'h0;
      end else
        case (state)
          IDLE: if (launch) begin
            state <= SYNC;
            latch <= rdVal;
            oe <= 1'b1;
            dout <= 4'h0;
          end
          SYNC: begin
            state <= DLO;
            dout <= latch[3:0];
          end
          DLO: begin
            state <= DHI;
            dout <= latch[7:4];
          end
          DHI: begin
            state <= TAR;
            dout <= 4'hF;
          end
          default: begin
            state <= IDLE;
            oe <= 1'b0;
            dout <= 4'h0;
          end
        endcase
    end
  assign bus.LpcDout = dout;
  assign bus.LpcOe = oe;
  assign bus.CtrlOut = ctrl;
  assign bus.RdBusy = state != IDLE;
endmodule

// File: tb/tb_lpc_reg_responder.sv
// tb_lpc_reg_responder: directed and randomized LPC reads/writes checked against a register-map model
module tb_lpc_reg_responder;
  logic LpcClock = 1'b0;
  logic PciReset = 1'b0;
  lpc_reg_responder_if bus ();
  lpc_reg_responder dut (.LpcClock(LpcClock), .PciReset(PciReset), .bus(bus));
  always #15 LpcClock = ~LpcClock;
  int vectors = 0;
  int miscompares = 0;
  logic [47:0] mCtrl = 48'h0;
  logic [7:0] mStatus = 8'h00;
  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] mRead(input logic [4:0] off);
    if (off == 0) return 8'hA5;
    if (off == 1) return 8'h10;
    if (off >= 2 && off <= 7) return mCtrl[(int'(off) - 2) * 8 +: 8];
    if (off == 8) return bus.Data80;
    if (off == 9) return mStatus;
    return 8'hFF;
  endfunction
  task automatic tick();
    if (bus.Wr && bus.AddrReg[4:0] >= 2 && bus.AddrReg[4:0] <= 7)
      mCtrl[(int'(bus.AddrReg[4:0]) - 2) * 8 +: 8] = bus.DataWr;
    mStatus = (mStatus & ~((bus.Wr && bus.AddrReg[4:0] == 9) ? bus.DataWr : 8'h00)) | bus.StatusIn;
    @(posedge LpcClock);
    #1;
  endtask
  task automatic rd(input logic [7:0] addr, input bit abort);
    logic [7:0] e;
    e = mRead(addr[4:0]);
    bus.AddrReg = addr;
    bus.Opcode = 1'b0;
    bus.AccessHit = 1'b1;
    bus.DecState = 5'b00001;
    tick();
    bus.DecState = 5'b00010;
    chk("sync_oe", bus.LpcOe, 1);
    chk("sync_lad", bus.LpcDout, 0);
    chk("sync_busy", bus.RdBusy, 1);
    tick();
    bus.DecState = 5'b00100;
    chk("dlo_lad", bus.LpcDout, e[3:0]);
    if (abort) begin
      bus.LpcFrame = 1'b0;
      tick();
      bus.LpcFrame = 1'b1;
      bus.DecState = 5'b00000;
      chk("abort_oe", bus.LpcOe, 0);
      chk("abort_busy", bus.RdBusy, 0);
      tick();
      chk("abort_stay_idle", bus.LpcOe, 0);
    end else begin
      tick();
      bus.DecState = 5'b01000;
      chk("dhi_lad", bus.LpcDout, e[7:4]);
      chk("dhi_oe", bus.LpcOe, 1);
      tick();
      bus.DecState = 5'b10000;
      chk("tar_lad", bus.LpcDout, 4'hF);
      tick();
      bus.DecState = 5'b00000;
      chk("release_oe", bus.LpcOe, 0);
      chk("release_busy", bus.RdBusy, 0);
    end
    bus.AccessHit = 1'b0;
  endtask
  task automatic wr(input logic [7:0] addr, input logic [7:0] data, input logic [7:0] sin);
    bus.Wr = 1'b1;
    bus.AddrReg = addr;
    bus.DataWr = data;
    bus.StatusIn = sin;
    bus.Opcode = 1'b1;
    bus.AccessHit = 1'b1;
    bus.DecState = 5'b00001;
    tick();
    bus.Wr = 1'b0;
    bus.StatusIn = 8'h00;
    bus.DecState = 5'b00000;
    bus.AccessHit = 1'b0;
    chk("wr_ctrl", bus.CtrlOut, mCtrl);
    chk("wr_no_oe", bus.LpcOe, 0);
    tick();
    chk("wr_no_oe2", bus.LpcOe, 0);
  endtask
  initial begin
    bus.LpcFrame = 1'b1;
    bus.Opcode = 1'b0;
    bus.Wr = 1'b0;
    bus.AddrReg = 8'h00;
    bus.DataWr = 8'h00;
    bus.DecState = 5'b00000;
    bus.AccessHit = 1'b0;
    bus.Data80 = 8'h00;
    bus.StatusIn = 8'h00;
    repeat (2) @(posedge LpcClock);
    #1;
    chk("rst_oe", bus.LpcOe, 0);
    chk("rst_lad", bus.LpcDout, 0);
    chk("rst_busy", bus.RdBusy, 0);
    chk("rst_ctrl", bus.CtrlOut, 48'h0);
    PciReset = 1'b1;
    tick();
    rd(8'h00, 0);
    wr(8'h02, 8'h3C, 8'h00);
    chk("ctrl_3c", bus.CtrlOut[7:0], 8'h3C);
    rd(8'h02, 0);
    bus.StatusIn = 8'h81;
    tick();
    bus.StatusIn = 8'h00;
    rd(8'h09, 0);
    wr(8'h09, 8'h01, 8'h00);
    rd(8'h09, 0);
    wr(8'h09, 8'h80, 8'h80);
    rd(8'h09, 0);
    rd(8'h15, 0);
    wr(8'h00, 8'h55, 8'h00);
    rd(8'h00, 0);
    rd(8'h02, 1);
    bus.Data80 = 8'h7E;
    rd(8'h08, 0);
    bus.AddrReg = 8'h02;
    bus.AccessHit = 1'b0;
    bus.Opcode = 1'b0;
    bus.DecState = 5'b00001;
    tick();
    bus.DecState = 5'b00000;
    chk("port80_no_oe", bus.LpcOe, 0);
    repeat (40) begin
      if ($urandom_range(1) == 1)
        wr(8'($urandom), 8'($urandom), 8'($urandom));
      else begin
        bus.Data80 = 8'($urandom);
        rd(8'($urandom), $urandom_range(7) == 0);
      end
    end
    bus.AddrReg = 8'h00;
    bus.AccessHit = 1'b1;
    bus.DecState = 5'b00001;
    tick();
    bus.DecState = 5'b00000;
    bus.AccessHit = 1'b0;
    tick();
    PciReset = 1'b0;
    #1;
    mCtrl = 48'h0;
    mStatus = 8'h00;
    chk("midrst_oe", bus.LpcOe, 0);
    chk("midrst_lad", bus.LpcDout, 0);
    chk("midrst_busy", bus.RdBusy, 0);
    chk("midrst_ctrl", bus.CtrlOut, 48'h0);
    @(posedge LpcClock);
    #1;
    PciReset = 1'b1;
    tick();
    rd(8'h09, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lpc_reg_responder.md
Name: lpc_reg_responder

Overview:
- Sits directly downstream of the LPC address decoder and owns the board register bank for the 32-port I/O window.
- Commits decoded I/O writes (Wr, AddrReg, DataWr) into the register bank.
- For decoded I/O reads, drives the LPC response back onto the bus: SYNC, data low nibble, data high nibble, then the turnaround 4'hF cycle.
- Exposes control registers to board logic and gathers sticky status from it.

Parameters:
- BOARD_ID, 8'hA5, value returned at offset 0x00 (read-only).
- CPLD_REV, 8'h10, value returned at offset 0x01 (read-only).
- CTRL_RST, 48'h0, reset value of control registers 0x02..0x07; byte n-2 of the vector belongs to offset n.

Ports:
- LpcClock  in  1  33 MHz LPC clock; all state updates on its rising edge.
- PciReset  in  1  asynchronous, active-low reset.
- LpcFrame  in  1  LPC frame, active low; low during a response aborts it.
- Opcode  in  1  decoded direction of the current cycle (0 = read, 1 = write).
- Wr  in  1  one-cycle write strobe from the decoder.
- AddrReg  in  8  decoded register address; only [4:0] is used as the offset.
- DataWr  in  8  decoded write data.
- DecState  in  5  decoder phase bits [10:6]; bit k is high for exactly the cycle of phase k.
- AccessHit  in  1  high while the current cycle hit the 32-port window (not port 80).
- Data80  in  8  latched port-80 POST code.
- StatusIn  in  8  per-bit event inputs, synchronous to LpcClock.
- LpcDout  out  4  nibble driven onto LAD[3:0].
- LpcOe  out  1  LAD output enable.
- CtrlOut  out  48  contents of control registers 0x02..0x07, offset 0x02 in [7:0].
- RdBusy  out  1  high whenever the response FSM is not IDLE.

Behaviour:
- Reset (PciReset low, async): FSM = IDLE; LpcOe = 0; LpcDout = 4'h0; RdBusy = 0; CtrlOut = CTRL_RST; status register = 8'h00; read latch = 8'h00.
- Register map, read value by offset:
  - 0x00: BOARD_ID.
  - 0x01: CPLD_REV.
  - 0x02..0x07: read/write control registers.
  - 0x08: Data80 (read-only).
  - 0x09: sticky status, write-1-to-clear.
  - 0x0A..0x1F: read as 8'hFF.
- Writes to read-only or unmapped offsets are ignored.
- Write: at a rising edge with Wr = 1 and AddrReg[4:0] in 0x02..0x07, DataWr is stored; CtrlOut shows the new value the next cycle.
- Status register:
  - Every cycle: status <= (status & ~clr) | StatusIn.
  - clr = DataWr when Wr = 1 and offset = 0x09, otherwise 0.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Read launch:
  - At an edge where DecState[6] = 1, AccessHit = 1, Opcode = 0 and LpcFrame = 1, the selected register value is snapshotted into the read latch and the FSM enters SYNC.
  - The latched value is returned even if the register changes during the response.
- FSM: IDLE -> SYNC -> DLO -> DHI -> TAR -> IDLE, one clock per state. Registered outputs by state:
  - IDLE: LpcOe = 0.
  - SYNC: LpcOe = 1, LpcDout = 4'h0.
  - DLO: LpcOe = 1, LpcDout = latch[3:0].
  - DHI: LpcOe = 1, LpcDout = latch[7:4].
  - TAR: LpcOe = 1, LpcDout = 4'hF.
- Bus timing:
  - SYNC occupies the decoder's phase-7 cycle.
  - LAD is released (LpcOe = 0) in the phase-11 cycle, 5 clocks after the launch edge.
- Abort: at any edge with LpcFrame = 0 while the FSM is not IDLE, the FSM goes to IDLE and LpcOe = 0 the next cycle. No retry.
- Write cycles and port-80 cycles (AccessHit = 0) never launch a response; LpcOe stays 0.
- Launch conditions seen while the FSM is busy are ignored. This cannot occur in legal LPC traffic.
- Reset asserted mid-response: outputs go to their reset values immediately (asynchronously).

Test Plan:
- Reset release -> LpcOe = 0, CtrlOut = 48'h0, RdBusy = 0. Then read offset 0x00 -> LAD sequence 0, 5, A, F over 4 cycles, then LpcOe = 0.
- Wr pulse, AddrReg = 0x02, DataWr = 0x3C -> CtrlOut[7:0] = 0x3C next cycle. Read offset 0x02 -> LAD 0, C, 3, F.
- StatusIn = 0x81 for one cycle -> read 0x09 returns 0x81. Write 0x01 to 0x09 -> next read returns 0x80. Write 0x80 to 0x09 in the same cycle StatusIn[7] = 1 -> bit 7 stays 1.
- Read offset 0x15 -> LAD 0, F, F, F. Write 0x55 to 0x00 -> subsequent read still returns BOARD_ID.
- Read 0x02 with LpcFrame driven low during the DLO cycle -> LpcOe = 0 on the next cycle, RdBusy = 0, FSM IDLE.
- Data80 = 0x7E, read 0x08 -> LAD 0, E, 7, F. Write cycle with DecState[6] = 1 -> LpcOe never asserts.
